rr_packet_scheduler4: RTL and testbench

Packet-granular round-robin scheduler for four ingress requesters sharing one egress datapath. Unlike the per-cycle arbiter, it holds a grant for a whole packet, releases it on the last beat (or a beat-count timeout), inserts one idle cycle, and rotates priority past the last winner. It drives the mux select and enable of the shared 40G egress stage.

---
 rtl/rr_packet_scheduler4_if.sv | 22 ++
 rtl/rr_packet_scheduler4.sv | 101 ++++++++++
 tb/tb_rr_packet_scheduler4.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rr_packet_scheduler4_if.sv
// Request/beat inputs and grant outputs of the packet-granular round-robin
// scheduler, bundled so the egress stage and the requesters share one port.
interface rr_packet_scheduler4_if;
  logic       qArbitEnable;
  logic [3:0] qvRequest;
  logic       qBeatValid;
  logic       qBeatEop;
  logic [3:0] qvGrant;
  logic [1:0] qvGrantIndex;
  logic       qGrantValid;
  logic       qTimeout;

  modport master (
    output qArbitEnable, qvRequest, qBeatValid, qBeatEop,
    input  qvGrant, qvGrantIndex, qGrantValid, qTimeout
  );

  modport slave (
    input  qArbitEnable, qvRequest, qBeatValid, qBeatEop,
    output qvGrant, qvGrantIndex, qGrantValid, qTimeout
  );
endinterface

// File: rtl/rr_packet_scheduler4.sv
// Four-port round-robin scheduler that holds each grant for a whole packet,
// releases on EOP or beat-count timeout, and rotates priority past the winner.
module rr_packet_scheduler4 #(
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  rr_packet_scheduler4_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [3:0]       r_grant,   w_grant_nxt;
  logic [1:0]       r_idx,     w_idx_nxt;
  logic [1:0]       r_ptr,     w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_valid;

  logic       w_pick_found;
  logic [1:0] w_pick_idx;

  // First requester at or after the start pointer; the lowest offset wins.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.qvRequest[r_ptr + 2'(i)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (bus.qArbitEnable && w_pick_found) begin
          w_grant_nxt = 4'(1) << w_pick_idx;
          w_idx_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Grant is frozen; only beats move the packet toward release.
        if (bus.qBeatValid) begin
          if (bus.qBeatEop || (r_cnt == LAST_BEAT)) begin
            w_grant_nxt   = '0;
            w_ptr_nxt     = r_idx + 2'd1;
            w_cnt_nxt     = '0;
            w_timeout_nxt = !bus.qBeatEop;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_valid   <= |w_grant_nxt;
    end
  end

  assign bus.qvGrant      = r_grant;
  assign bus.qvGrantIndex = r_idx;
  assign bus.qGrantValid  = r_valid;
  assign bus.qTimeout     = r_timeout;

endmodule

// File: tb/tb_rr_packet_scheduler4.sv
// Vector table plus scoreboard bench for rr_packet_scheduler4 (MAX_BEATS=4),
// with hand-written sequences for reset behaviour.
module tb_rr_packet_scheduler4;

  localparam int unsigned MAX_BEATS = 4;

  logic clock;
  logic reset;

  rr_packet_scheduler4_if bus ();

  rr_packet_scheduler4 #(.MAX_BEATS(MAX_BEATS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       bv;
    logic       eop;
    logic [3:0] g;
    logic [1:0] idx;
    logic       to;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic en, input logic [3:0] req, input logic bv,
                     input logic eop, input logic [3:0] g, input logic [1:0] idx,
                     input logic to);
    vec_t v;
    v.en = en; v.req = req; v.bv = bv; v.eop = eop;
    v.g = g; v.idx = idx; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic check_now(input string name, input exp_t e);
    n_vec++;
    if (bus.qvGrant !== e.g || bus.qvGrantIndex !== e.idx ||
        bus.qGrantValid !== e.v || bus.qTimeout !== e.to) begin
      n_err++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b to=%b, want grant=%b idx=%0d valid=%b to=%b",
               name, bus.qvGrant, bus.qvGrantIndex, bus.qGrantValid, bus.qTimeout,
               e.g, e.idx, e.v, e.to);
    end
  endtask

  // Drive at negedge, expectation queued, popped after the next rising edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    bus.qArbitEnable = v.en;
    bus.qvRequest    = v.req;
    bus.qBeatValid   = v.bv;
    bus.qBeatEop     = v.eop;
    e.g = v.g; e.idx = v.idx; e.v = |v.g; e.to = v.to;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      check_now(name, got);
    end
    @(negedge clock);
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] idx, input logic to);
    exp_t e;
    e.g = g; e.idx = idx; e.v = |g; e.to = to;
    return e;
  endfunction

  task automatic vec(input logic en, input logic [3:0] req, input logic bv,
                     input logic eop, input logic [3:0] g, input logic [1:0] idx,
                     input logic to, input string name);
    vec_t v;
    v.en = en; v.req = req; v.bv = bv; v.eop = eop;
    v.g = g; v.idx = idx; v.to = to;
    apply(v, name);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Single port, EOP on 3rd beat, index held in idle
    add(1, 4'b0100, 0, 0, 4'b0100, 2'd2, 0);
    add(1, 4'b0100, 1, 0, 4'b0100, 2'd2, 0);
    add(1, 4'b0100, 1, 0, 4'b0100, 2'd2, 0);
    add(1, 4'b0100, 1, 1, 4'b0000, 2'd2, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'd2, 0);
    // Park pointer at 0 via a port-3 packet, then fairness 0,1,2,3,0
    add(1, 4'b1000, 0, 0, 4'b1000, 2'd3, 0);
    add(1, 4'b1000, 1, 1, 4'b0000, 2'd3, 0);
    add(1, 4'b1111, 0, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 0, 0, 4'b0010, 2'd1, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 2'd1, 0);
    add(1, 4'b1111, 0, 0, 4'b0100, 2'd2, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 2'd2, 0);
    add(1, 4'b1111, 0, 0, 4'b1000, 2'd3, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 2'd3, 0);
    add(1, 4'b1111, 0, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 2'd0, 0);
    // Wrap and skip; beats in idle are ignored
    add(1, 4'b1000, 0, 0, 4'b1000, 2'd3, 0);
    add(1, 4'b1000, 1, 1, 4'b0000, 2'd3, 0);
    add(1, 4'b0110, 1, 1, 4'b0010, 2'd1, 0);
    add(1, 4'b0110, 1, 1, 4'b0000, 2'd1, 0);
    add(1, 4'b0101, 0, 0, 4'b0100, 2'd2, 0);
    add(1, 4'b0101, 1, 1, 4'b0000, 2'd2, 0);
    // Timeout after the 4th beat (with a gap cycle), then next port
    add(1, 4'b0011, 0, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b0011, 1, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b0011, 1, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b0011, 0, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b0011, 1, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b0011, 1, 0, 4'b0000, 2'd0, 1);
    add(1, 4'b0011, 0, 0, 4'b0010, 2'd1, 0);
    // EOP on the 4th beat: normal release, no pulse
    add(1, 4'b0011, 1, 0, 4'b0010, 2'd1, 0);
    add(1, 4'b0011, 1, 0, 4'b0010, 2'd1, 0);
    add(1, 4'b0011, 1, 0, 4'b0010, 2'd1, 0);
    add(1, 4'b0011, 1, 1, 4'b0000, 2'd1, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 2'd1, 0);
    // Hold through request drop and enable low; no grant while disabled
    add(1, 4'b0001, 0, 0, 4'b0001, 2'd0, 0);
    add(1, 4'b0000, 1, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b1111, 1, 0, 4'b0001, 2'd0, 0);
    add(0, 4'b1111, 1, 1, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 0, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 0, 0, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 0, 0, 4'b0010, 2'd1, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 2'd1, 0);

    bus.qArbitEnable = 1'b0;
    bus.qvRequest    = 4'b0000;
    bus.qBeatValid   = 1'b0;
    bus.qBeatEop     = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_now("reset_state", mk(4'b0000, 2'd0, 1'b0));
    reset = 1'b0;

    foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

    // Async reset mid-packet with pointer at 2
    vec(1, 4'b0100, 0, 0, 4'b0100, 2'd2, 0, "rst_grant");
    vec(1, 4'b0100, 1, 0, 4'b0100, 2'd2, 0, "rst_beat");
    #2;
    reset = 1'b1;
    #1;
    check_now("async_reset", mk(4'b0000, 2'd0, 1'b0));
    @(negedge clock);
    reset = 1'b0;
    vec(1, 4'b1010, 0, 0, 4'b0010, 2'd1, 0, "rst_ptr0");
    vec(1, 4'b1010, 1, 1, 4'b0000, 2'd1, 0, "rst_rel");
    vec(1, 4'b1000, 0, 0, 4'b1000, 2'd3, 0, "rst_port3");
    vec(1, 4'b1000, 1, 1, 4'b0000, 2'd3, 0, "rst_port3_rel");

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
